mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
// Shares the single pipelined main memory between the I-cache and D-cache fill FSMs (and D-cache write-through stores).
// Grants memory ownership to one cache at a time and forwards that cache's enable, address and write signals.
// Tracks in-flight reads and steers returning memory_data_valid/data to the cache that issued them.
// Sits between both cache controllers and the memory model; the grant deassertion acts as the cache-side stall.
// PARAMETERS
// ADDR_W   16  address width
// DATA_W   16  data word width
// MEM_LAT  4   memory read latency, cycles from mem_enable to mem_data_valid
// CNT_W    3   width of in-flight read counter; must hold MEM_LAT
// PORTS
// clk            in   1       clock, all state on rising edge
// rst            in   1       synchronous active-high reset
// icache_req     in   1       I-cache requests memory ownership; held high for the whole fill
// icache_en      in   1       I-cache issues a read this cycle (honoured only while icache_grant)
// icache_addr    in   ADDR_W  I-cache read address
// dcache_req     in   1       D-cache requests memory ownership
// dcache_en      in   1       D-cache issues an access this cycle (honoured only while dcache_grant)
// dcache_wr      in   1       1 = write, 0 = read, qualified by dcache_en
// dcache_addr    in   ADDR_W  D-cache address
// dcache_wdata   in   DATA_W  D-cache store data
// mem_data_out   in   DATA_W  read data from memory
// mem_data_valid in   1       memory read data valid
// icache_grant   out  1       I-cache owns memory
// dcache_grant   out  1       D-cache owns memory
// icache_valid   out  1       returned read data belongs to I-cache
// dcache_valid   out  1       returned read data belongs to D-cache
// rdata          out  DATA_W  mem_data_out passed through to both caches
// mem_enable     out  1       memory access enable
// mem_wr         out  1       memory write enable
// mem_addr       out  ADDR_W  memory address
// mem_data_in    out  DATA_W  memory write data
// busy           out  1       state != IDLE
// BEHAVIOUR
// - States: IDLE, GRANT_I, GRANT_D, DRAIN. Registers: state, owner {NONE,I,D}, last_served {I,D}, inflight[CNT_W-1:0].
// - Reset: state=IDLE, owner=NONE, last_served=I, inflight=0; all outputs 0 except rdata (pass-through).
// - IDLE: dcache_req & (!icache_req | last_served==I) -> GRANT_D, owner=D, last_served=D.
//   Else if icache_req -> GRANT_I, owner=I, last_served=I. Else stay. Tie goes round-robin; first tie after reset goes to D.
// - Grant is registered: req seen in IDLE at cycle t -> grant high at t+1. Requester enables are ignored before the grant.
// - GRANT_X: mem_enable = X_en; mem_addr/mem_wr/mem_data_in taken from X (mem_wr=0, mem_data_in=0 for I-cache).
//   With no grant, mem_enable=mem_wr=0 and addr/data=0.
// - GRANT_X with req_X low -> DRAIN at the next edge; grant drops at that edge. The other requester waits.
// - DRAIN: no enable forwarded; owner is held. Go to IDLE when inflight==0 and mem_data_valid==0.
// - After DRAIN, a full IDLE cycle always occurs before the next grant. Switch cost = 2 cycles minimum after inflight drains.
// - inflight: +1 on a forwarded read (mem_enable & !mem_wr); -1 on mem_data_valid.
//   A simultaneous +1/-1 leaves it unchanged. Writes are not counted. The decrement saturates at 0.
//   Increment beyond MEM_LAT cannot happen with one issue per cycle; the bench asserts on it.
// - Steering (combinational): icache_valid = mem_data_valid & owner==I; dcache_valid likewise for D.
//   Valid is steered in GRANT and DRAIN states. A valid with owner==NONE is dropped.
// - Reset mid-fill: everything clears the next cycle. Stale valids arriving afterwards are dropped (owner NONE).
//   inflight saturates at 0.
// - req deasserted and reasserted within a grant: the deassertion always enters DRAIN; ownership is never retained.
// TESTING
// - Reset, then icache_req=1 at t0 -> icache_grant=1 at t1.
//   8 reads at 0x0100..0x010E -> 8 icache_valid pulses starting at t1+MEM_LAT; dcache_valid stays 0.
// - Both reqs high at t0 after reset -> dcache_grant first.
//   After D drops req and drains, I is granted; the next tie goes to D.
// - D write at 0x2000, data 0xBEEF -> mem_wr=1, mem_enable=1, mem_data_in=0xBEEF for 1 cycle; inflight stays 0.
//   req drop -> DRAIN -> IDLE in 2 cycles.
// - I drops req with 3 reads in flight -> state held in DRAIN for 3 valids, all routed to icache_valid.
//   dcache_grant rises only after the IDLE cycle.
// - rst=1 during GRANT_D with 2 reads in flight -> next cycle all grants 0, busy=0.
//   Both late mem_data_valid pulses are dropped (no *_valid); inflight stays 0.
// - Back-to-back read issue with simultaneous return every cycle -> inflight constant at MEM_LAT, never exceeds it.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one pipelined memory between I-cache and D-cache fills and steers read returns to the cache that issued them.
// Latency: grant 1 cycle after req, forwarding and steering are combinational. Backpressure: a low grant stalls that cache; switching owners drains in-flight reads and then spends one IDLE cycle.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req,
    input  logic              icache_en,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_req,
    input  logic              dcache_en,
    input  logic              dcache_wr,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] dcache_wdata,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_data_valid,
    output logic              icache_grant,
    output logic              dcache_grant,
    output logic              icache_valid,
    output logic              dcache_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DRAIN} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;
    typedef enum logic {LAST_I, LAST_D} last_t;

    localparam logic [CNT_W-1:0] LAT_MAX = CNT_W'(MEM_LAT);

    state_t            state;
    owner_t            owner;
    last_t             last_served;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  inflight_nxt;
    logic              rd_issue;

    always_comb begin
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        if (icache_grant) begin
            mem_enable = icache_en;
            if (icache_en) mem_addr = icache_addr;
        end else if (dcache_grant) begin
            mem_enable = dcache_en;
            mem_wr     = dcache_en & dcache_wr;
            if (dcache_en) mem_addr = dcache_addr;
            if (dcache_en & dcache_wr) mem_data_in = dcache_wdata;
        end
    end

    // Only reads produce a return, so only reads are tracked; both ends saturate.
    always_comb begin
        rd_issue     = mem_enable & ~mem_wr;
        inflight_nxt = inflight;
        if (rd_issue && !mem_data_valid && inflight != LAT_MAX)
            inflight_nxt = inflight + CNT_W'(1);
        else if (!rd_issue && mem_data_valid && inflight != '0)
            inflight_nxt = inflight - CNT_W'(1);
    end

    assign icache_valid = mem_data_valid & (owner == OWN_I);
    assign dcache_valid = mem_data_valid & (owner == OWN_D);
    assign rdata        = mem_data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= OWN_NONE;
            last_served  <= LAST_I;
            inflight     <= '0;
            icache_grant <= 1'b0;
            dcache_grant <= 1'b0;
            busy         <= 1'b0;
        end else begin
            inflight <= inflight_nxt;
            case (state)
                IDLE: begin
                    if (dcache_req && (!icache_req || last_served == LAST_I)) begin
                        state        <= GRANT_D;
                        owner        <= OWN_D;
                        last_served  <= LAST_D;
                        dcache_grant <= 1'b1;
                        busy         <= 1'b1;
                    end else if (icache_req) begin
                        state        <= GRANT_I;
                        owner        <= OWN_I;
                        last_served  <= LAST_I;
                        icache_grant <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                GRANT_I: begin
                    if (!icache_req) begin
                        state        <= DRAIN;
                        icache_grant <= 1'b0;
                    end
                end
                GRANT_D: begin
                    if (!dcache_req) begin
                        state        <= DRAIN;
                        dcache_grant <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Owner stays put so late returns still reach the cache that asked for them.
                    if (inflight == '0 && !mem_data_valid) begin
                        state <= IDLE;
                        owner <= OWN_NONE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    owner        <= OWN_NONE;
                    icache_grant <= 1'b0;
                    dcache_grant <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
